tmds_encoder: RTL and testbench

Three-channel DVI/HDMI TMDS encoder that sits directly downstream of the HDMI timing controller. It consumes the controller's pixel stream (`HDMI_PX`, `DE`, `HSYNC`, `VSYNC`) in the `CLK_PX` domain and produces three 10-bit TMDS symbols per pixel clock for the serializer stage. It performs 8b/10b transition-minimised encoding with per-channel running-disparity tracking during active video, and emits control tokens during blanking.

---
 rtl/tmds_encoder.sv | 146 ++++++++++++++
 tb/tb_tmds_encoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// Three-channel DVI/HDMI TMDS encoder: 8b/10b transition-minimised data
// symbols with running disparity during active video, control tokens during
// blanking. Two register stages per channel, so symbols appear two CLK_PX
// edges after their inputs are sampled.

module tmds_channel (
  input  logic       CLK_PX,
  input  logic       RST_n,
  input  logic       de,
  input  logic       c0,
  input  logic       c1,
  input  logic [7:0] d,
  output logic [9:0] sym
);

  logic [3:0]        n1d;
  logic              use_xnor;
  logic [8:0]        qm;
  logic [3:0]        n1qm;

  logic [8:0]        qm_r;
  logic [3:0]        n1q_r;
  logic              de_r;
  logic [1:0]        c_r;
  logic              v_r;

  logic [3:0]        n0q;
  logic signed [4:0] diff;
  logic signed [4:0] cnt_r;
  logic signed [4:0] cnt_nx;
  logic [9:0]        sym_nx;

  // Stage 1 combinational: pick XOR/XNOR chain to minimise transitions.
  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, d[i]};
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    qm = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    n1qm = '0;
    for (int i = 0; i < 8; i++) n1qm = n1qm + {3'b000, qm[i]};
  end

  // Stage 1 register; v_r keeps stage 2 at zero until real data has arrived.
  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      qm_r  <= '0;
      n1q_r <= '0;
      de_r  <= 1'b0;
      c_r   <= 2'b00;
      v_r   <= 1'b0;
    end else begin
      qm_r  <= qm;
      n1q_r <= n1qm;
      de_r  <= de;
      c_r   <= {c1, c0};
      v_r   <= 1'b1;
    end
  end

  // Stage 2 combinational: token or DC-balanced data symbol and new disparity.
  always_comb begin
    n0q    = 4'd8 - n1q_r;
    diff   = $signed({1'b0, n1q_r}) - $signed({1'b0, n0q});
    sym_nx = 10'h354;
    cnt_nx = '0;
    if (!de_r) begin
      case (c_r)
        2'b00:   sym_nx = 10'h354;
        2'b01:   sym_nx = 10'h0AB;
        2'b10:   sym_nx = 10'h154;
        default: sym_nx = 10'h2AB;
      endcase
    end else if ((cnt_r == 5'sd0) || (n1q_r == n0q)) begin
      sym_nx = {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]};
      cnt_nx = qm_r[8] ? (cnt_r + diff) : (cnt_r - diff);
    end else if (((cnt_r > 5'sd0) && (n1q_r > n0q)) ||
                 ((cnt_r < 5'sd0) && (n0q > n1q_r))) begin
      sym_nx = {1'b1, qm_r[8], ~qm_r[7:0]};
      cnt_nx = cnt_r - diff + (qm_r[8] ? 5'sd2 : 5'sd0);
    end else begin
      sym_nx = {1'b0, qm_r[8], qm_r[7:0]};
      cnt_nx = cnt_r + diff - (qm_r[8] ? 5'sd0 : 5'sd2);
    end
  end

  // Stage 2 register: output symbol and running disparity.
  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      sym   <= '0;
      cnt_r <= '0;
    end else if (v_r) begin
      sym   <= sym_nx;
      cnt_r <= cnt_nx;
    end
  end

endmodule

module tmds_encoder (
  input  logic        CLK_PX,
  input  logic        RST_n,
  input  logic        DE,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic [23:0] HDMI_PX,
  output logic [9:0]  TMDS_CH0,
  output logic [9:0]  TMDS_CH1,
  output logic [9:0]  TMDS_CH2
);

  // Blue carries the syncs; green and red always send the 00 control token.
  tmds_channel u_ch0 (
    .CLK_PX (CLK_PX),
    .RST_n  (RST_n),
    .de     (DE),
    .c0     (HSYNC),
    .c1     (VSYNC),
    .d      (HDMI_PX[7:0]),
    .sym    (TMDS_CH0)
  );

  tmds_channel u_ch1 (
    .CLK_PX (CLK_PX),
    .RST_n  (RST_n),
    .de     (DE),
    .c0     (1'b0),
    .c1     (1'b0),
    .d      (HDMI_PX[15:8]),
    .sym    (TMDS_CH1)
  );

  tmds_channel u_ch2 (
    .CLK_PX (CLK_PX),
    .RST_n  (RST_n),
    .de     (DE),
    .c0     (1'b0),
    .c1     (1'b0),
    .d      (HDMI_PX[23:16]),
    .sym    (TMDS_CH2)
  );

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: fixed vector table, hand-written reset sequences,
// and a randomised soak against a behavioural model plus symbol decoding.

module tb_tmds_encoder;

  logic        CLK_PX = 1'b0;
  logic        RST_n  = 1'b0;
  logic        DE     = 1'b0;
  logic        HSYNC  = 1'b0;
  logic        VSYNC  = 1'b0;
  logic [23:0] HDMI_PX = '0;
  logic [9:0]  TMDS_CH0, TMDS_CH1, TMDS_CH2;

  tmds_encoder dut (
    .CLK_PX   (CLK_PX),
    .RST_n    (RST_n),
    .DE       (DE),
    .HSYNC    (HSYNC),
    .VSYNC    (VSYNC),
    .HDMI_PX  (HDMI_PX),
    .TMDS_CH0 (TMDS_CH0),
    .TMDS_CH1 (TMDS_CH1),
    .TMDS_CH2 (TMDS_CH2)
  );

  always #5 CLK_PX = ~CLK_PX;

  int tests  = 0;
  int errors = 0;

  // Model state: the symbol now on the outputs depends on the previous step's inputs.
  int          mcnt [3];
  logic [9:0]  exp_sym [3];
  logic        m_valid;
  logic        p_de, p_hs, p_vs;
  logic [23:0] p_px;
  logic        out_valid, out_de;
  logic [23:0] out_px;

  typedef struct {
    logic        de, hs, vs;
    logic [23:0] px;
    logic [9:0]  e0, e1, e2;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      exp_sym[i] = '0;
    end
    m_valid = 1'b0;
  endtask

  // Encoder model: transition-minimised word from prefix parity, then choose
  // inversion by disparity; disparity moves by the symbol's ones-minus-zeros.
  task automatic model_enc(input int ch, input logic de, input logic [1:0] c,
                           input logic [7:0] d, output logic [9:0] sym);
    int n1, nq;
    logic xn;
    logic [8:0] q;
    logic [7:0] mask;
    if (!de) begin
      case (c)
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      mcnt[ch] = 0;
      return;
    end
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    for (int i = 0; i < 8; i++) begin
      mask = 8'hFF >> (7 - i);
      q[i] = (^(d & mask)) ^ (xn && (i % 2 == 1));
    end
    q[8] = !xn;
    nq = $countones(q[7:0]);
    if (mcnt[ch] == 0 || nq == 4)
      sym = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
    else if ((mcnt[ch] > 0 && nq > 4) || (mcnt[ch] < 0 && nq < 4))
      sym = {1'b1, q[8], ~q[7:0]};
    else
      sym = {1'b0, q[8], q[7:0]};
    mcnt[ch] = mcnt[ch] + 2 * $countones(sym) - 10;
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] w, d;
    w = s[9] ? ~s[7:0] : s[7:0];
    d[0] = w[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return d;
  endfunction

  task automatic step(input logic de, input logic hs, input logic vs, input logic [23:0] px);
    DE = de; HSYNC = hs; VSYNC = vs; HDMI_PX = px;
    @(posedge CLK_PX);
    #1;
    out_valid = m_valid;
    out_de    = p_de;
    out_px    = p_px;
    if (m_valid) begin
      model_enc(0, p_de, {p_vs, p_hs}, p_px[7:0],   exp_sym[0]);
      model_enc(1, p_de, 2'b00,        p_px[15:8],  exp_sym[1]);
      model_enc(2, p_de, 2'b00,        p_px[23:16], exp_sym[2]);
    end
    p_de = de; p_hs = hs; p_vs = vs; p_px = px;
    m_valid = 1'b1;
  endtask

  task automatic check3(input string name, input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
    chk({name, "_ch0"}, TMDS_CH0, e0);
    chk({name, "_ch1"}, TMDS_CH1, e1);
    chk({name, "_ch2"}, TMDS_CH2, e2);
  endtask

  task automatic apply_reset();
    RST_n = 1'b0;
    #3;
    check3("reset_zero", 10'h000, 10'h000, 10'h000);
    model_reset();
    @(negedge CLK_PX);
    RST_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 24'h123456, 10'h0AB, 10'h354, 10'h354};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 24'hABCDEF, 10'h154, 10'h354, 10'h354};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 24'h000000, 10'h2AB, 10'h354, 10'h354};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h100, 10'h100, 10'h100};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h3FF, 10'h3FF, 10'h3FF};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h100, 10'h100, 10'h100};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h100, 10'h100, 10'h100};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 24'hFFFFFF, 10'h200, 10'h200, 10'h200};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 24'h000000, 10'h2AB, 10'h354, 10'h354};

    p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0; p_px = '0;
    out_valid = 1'b0; out_de = 1'b0; out_px = '0;
    model_reset();

    // Reset then blanking with both syncs high.
    #2;
    check3("por_zero", 10'h000, 10'h000, 10'h000);
    @(negedge CLK_PX);
    RST_n = 1'b1;
    step(1'b0, 1'b1, 1'b1, 24'h0);
    check3("first_edge_hold", 10'h000, 10'h000, 10'h000);
    step(1'b0, 1'b1, 1'b1, 24'h0);
    check3("first_token", 10'h2AB, 10'h354, 10'h354);

    // Vector table: each entry's symbols appear one step later.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].px);
      if (i > 0) check3($sformatf("vec%0d", i - 1), tbl[i-1].e0, tbl[i-1].e1, tbl[i-1].e2);
    end
    step(1'b0, 1'b0, 1'b0, 24'h0);
    check3("vec11", tbl[11].e0, tbl[11].e1, tbl[11].e2);

    // Mid-line reset: disparity must not survive.
    step(1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    #2;
    apply_reset();
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check3("midrst_hold", 10'h000, 10'h000, 10'h000);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    check3("midrst_first", 10'h100, 10'h100, 10'h100);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    check3("midrst_second", 10'h3FF, 10'h3FF, 10'h3FF);

    // Randomised soak over a short frame-like raster with random DE glitches.
    for (int line = 0; line < 25; line++) begin
      for (int x = 0; x < 800; x++) begin
        logic de_v, hs_v, vs_v;
        de_v = (x < 640) && (line < 20);
        if ($urandom_range(0, 49) == 0) de_v = !de_v;
        hs_v = !((x >= 656) && (x < 752));
        vs_v = !((line == 21) || (line == 22));
        step(de_v, hs_v, vs_v, $urandom);
        check3("soak", exp_sym[0], exp_sym[1], exp_sym[2]);
        if (out_valid && out_de) begin
          chk("decode_ch0", {2'b00, decode(TMDS_CH0)}, {2'b00, out_px[7:0]});
          chk("decode_ch1", {2'b00, decode(TMDS_CH1)}, {2'b00, out_px[15:8]});
          chk("decode_ch2", {2'b00, decode(TMDS_CH2)}, {2'b00, out_px[23:16]});
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
